// File: rtl/lsu_byte_master.sv
// -----------------------------------------------------------------------------
// lsu_byte_master
//
// Load/store initiator between the core's data-access request channel and a
// byte-wide data memory port. Each accepted word/half/byte request becomes one
// little-endian byte access per cycle. Loads are reassembled and sign- or
// zero-extended. Every request gets exactly one response. This lets the data
// memory be a plain byte array with no width decoding of its own.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   req_valid     core request valid
//   req_ready     unit can accept a request (high only while idle)
//   req_write     1 = store, 0 = load
//   req_size      00 word, 01 half, 10 byte, 11 reserved (error response)
//   req_unsigned  zero-extend half/byte loads when 1
//   req_addr      byte address, only [MEM_AW-1:0] is used
//   req_wdata     store data, low bytes used according to size
//   resp_valid    response available
//   resp_ready    core accepts the response
//   resp_rdata    extended load data, 0 for stores and errors
//   resp_err      request carried the reserved size
//   mem_en        byte access this cycle
//   mem_we        byte write strobe, only ever high together with mem_en
//   mem_addr      byte address, wraps modulo 2^MEM_AW
//   mem_wdata     write byte
//   mem_rdata     read byte, combinational from mem_addr in the same cycle
// -----------------------------------------------------------------------------
module lsu_byte_master #(
  parameter int MEM_AW = 10,
  parameter int DATA_W = 32   // fixed at 32; the byte lanes below assume it
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  state_t              state_q, state_d;

  // Captured request.
  logic                wr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [MEM_AW-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;

  // Byte sequencing: idx walks 0..last, last = number of bytes minus one.
  logic [1:0]          idx_q;
  logic [1:0]          last_q;

  // Load assembly and registered response.
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  // Combinational helpers.
  logic [DATA_W-1:0]   asm_now;
  logic [DATA_W-1:0]   ext_data;
  logic [7:0]          wbyte;
  logic                last_byte;

  // Address bits above the memory window are deliberately dropped.
  logic                addr_unused;
  assign addr_unused = ^req_addr[DATA_W-1:MEM_AW];

  assign last_byte = (idx_q == last_q);

  // Number of bytes minus one for each size; reserved size never transfers.
  function automatic logic [1:0] last_for_size(input logic [1:0] size);
    case (size)
      SIZE_WORD: last_for_size = 2'd3;
      SIZE_HALF: last_for_size = 2'd1;
      default:   last_for_size = 2'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb keeps every
  // path assigned, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (req_size == SIZE_RSVD) ? RESP : XFER;
        end
      end
      XFER: begin
        if (last_byte) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Current write byte lane.
  always_comb begin
    case (idx_q)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Memory outputs are decoded straight from the state register, so an
  // asynchronous reset removes mem_en in the same instant.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      XFER: begin
        mem_en    = 1'b1;
        mem_we    = wr_q;
        mem_addr  = base_q + MEM_AW'(idx_q);   // natural wrap at 2^MEM_AW
        mem_wdata = wbyte;
      end
      RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // ---------------------------------------------------------------------------
  // Load assembly and extension
  // ---------------------------------------------------------------------------
  // The byte arriving this cycle is merged in front of the register, so the
  // final response can be formed at the edge that ends the last byte access.
  // NOTE: combinational processes use blocking assignments; the later lane
  // overwrite below relies on that ordering.
  always_comb begin
    asm_now = asm_q;
    case (idx_q)
      2'd0:    asm_now[7:0]   = mem_rdata;
      2'd1:    asm_now[15:8]  = mem_rdata;
      2'd2:    asm_now[23:16] = mem_rdata;
      default: asm_now[31:24] = mem_rdata;
    endcase
  end

  always_comb begin
    ext_data = '0;
    if (!wr_q) begin
      case (size_q)
        SIZE_WORD: ext_data = asm_now;
        SIZE_HALF: ext_data = {{16{asm_now[15] & ~uns_q}}, asm_now[15:0]};
        SIZE_BYTE: ext_data = {{24{asm_now[7] & ~uns_q}}, asm_now[7:0]};
        default:   ext_data = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= SIZE_WORD;
      uns_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            base_q  <= req_addr[MEM_AW-1:0];
            wdata_q <= req_wdata;
            idx_q   <= 2'd0;
            last_q  <= last_for_size(req_size);
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= (req_size == SIZE_RSVD);
          end
        end
        XFER: begin
          if (!wr_q) begin
            asm_q <= asm_now;
          end
          if (last_byte) begin
            rdata_q <= ext_data;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_byte_master
//
// Self-checking bench for lsu_byte_master. A byte-array memory is attached to
// the DUT's memory port. A transaction-level model (shadow byte array plus a
// queue of expected per-cycle outputs built when each request is accepted)
// predicts every output; one compare process checks the DUT against it on
// every falling edge. Directed scenarios pin the model with literal values,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_lsu_byte_master;

  localparam int AW    = 10;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  always #5 clk = ~clk;

  lsu_byte_master #(.MEM_AW(AW), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Attached memory (what the DUT actually reads and writes)
  // ---------------------------------------------------------------------------
  logic [7:0] mem [MSIZE];
  bit         mem_loaded = 1'b0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MSIZE; i++) mem[i] <= 8'((i * 37 + 11) & 255);
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mem_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_en) mem_cycles <= mem_cycles + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: shadow memory + expected per-cycle outputs
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
  } exp_t;

  logic [7:0] ref_mem [MSIZE];
  exp_t       exp_q[$];
  bit         chk_en = 1'b0;

  // Single compare process: one expected entry per cycle while a request is in
  // flight, otherwise the idle expectation.
  always @(negedge clk) begin : compare
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = '{req_ready: 1'b1, resp_valid: 1'b0, resp_rdata: 32'h0, resp_err: 1'b0,
              mem_en: 1'b0, mem_we: 1'b0, mem_addr: '0, mem_wdata: 8'h00};
      end
      check("req_ready",  32'(req_ready),  32'(e.req_ready));
      check("resp_valid", 32'(resp_valid), 32'(e.resp_valid));
      check("mem_en",     32'(mem_en),     32'(e.mem_en));
      check("mem_we",     32'(mem_we),     32'(e.mem_we));
      if (e.mem_en) begin
        check("mem_addr",  32'(mem_addr),  32'(e.mem_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e.mem_wdata));
      end
      if (e.resp_valid) begin
        check("resp_rdata", resp_rdata,      e.resp_rdata);
        check("resp_err",   32'(resp_err),   32'(e.resp_err));
      end
    end
  end

  // One request/response. Entered and left at #1 after a rising edge with the
  // DUT idle in the current cycle. `hold` is the number of response cycles with
  // resp_ready low before the handshake.
  task automatic do_req(input bit wr, input bit [1:0] sz, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wd, input int hold,
                        output bit [31:0] got_rdata, output bit got_err,
                        output bit [31:0] exp_rdata);
    int        n;
    bit [9:0]  a;
    bit [7:0]  b;
    exp_t      e;
    n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 0;

    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk); #1;

    // Model: byte i goes to (addr + i) mod 1024, little-endian.
    exp_rdata = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = 10'((int'(addr[9:0]) + i) % MSIZE);
      b = 8'(wd >> (8 * i));
      e = '{req_ready: 1'b0, resp_valid: 1'b0, resp_rdata: 32'h0, resp_err: 1'b0,
            mem_en: 1'b1, mem_we: wr, mem_addr: a, mem_wdata: b};
      exp_q.push_back(e);
      if (wr) ref_mem[a] = b;
      else    exp_rdata = exp_rdata | (32'(ref_mem[a]) << (8 * i));
    end
    if (!wr && !uns && (n == 1 || n == 2) && exp_rdata[8 * n - 1])
      exp_rdata = exp_rdata | ~((32'h1 << (8 * n)) - 32'h1);
    for (int h = 0; h <= hold; h++) begin
      e = '{req_ready: 1'b0, resp_valid: 1'b1, resp_rdata: exp_rdata, resp_err: (sz == 2'd3),
            mem_en: 1'b0, mem_we: 1'b0, mem_addr: '0, mem_wdata: 8'h00};
      exp_q.push_back(e);
    end

    // Request inputs are junk from here on; the DUT must ignore them.
    req_valid    = 1'($urandom);
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    for (int i = 0; i < n; i++) begin
      resp_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    got_rdata  = resp_rdata;
    got_err    = resp_err;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit [31:0] got, expd;
    bit        gerr;
    int        mc0, c0, mism, r;
    bit [1:0]  sz;

    for (int i = 0; i < MSIZE; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err",   32'(resp_err),   32'h0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_mem_en",     32'(mem_en),     32'h0);
    check("rst_mem_we",     32'(mem_we),     32'h0);
    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    check("rst_mem_wdata",  32'(mem_wdata),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Store word 0xDEADBEEF at 0x010.
    mc0 = mem_cycles;
    do_req(1'b1, 2'b00, 1'b0, 32'h010, 32'hDEADBEEF, 0, got, gerr, expd);
    check("sw_rdata",  got, 32'h0);
    check("sw_err",    32'(gerr), 32'h0);
    check("sw_cycles", 32'(mem_cycles - mc0), 32'd4);
    check("sw_m010", 32'(mem[10'h010]), 32'hEF);
    check("sw_m011", 32'(mem[10'h011]), 32'hBE);
    check("sw_m012", 32'(mem[10'h012]), 32'hAD);
    check("sw_m013", 32'(mem[10'h013]), 32'hDE);

    // Load byte from 0x013, signed then unsigned.
    mc0 = mem_cycles;
    do_req(1'b0, 2'b10, 1'b0, 32'h013, 32'h0, 1, got, gerr, expd);
    check("lb_rdata",  got, 32'hFFFFFFDE);
    check("lb_model",  expd, 32'hFFFFFFDE);
    check("lb_cycles", 32'(mem_cycles - mc0), 32'd1);
    mc0 = mem_cycles;
    do_req(1'b0, 2'b10, 1'b1, 32'h013, 32'h0, 0, got, gerr, expd);
    check("lbu_rdata",  got, 32'h000000DE);
    check("lbu_cycles", 32'(mem_cycles - mc0), 32'd1);

    // Half store across the top of memory, then signed half load.
    do_req(1'b1, 2'b01, 1'b0, 32'h3FF, 32'h12348001, 0, got, gerr, expd);
    check("sh_m3ff", 32'(mem[10'h3FF]), 32'h01);
    check("sh_m000", 32'(mem[10'h000]), 32'h80);
    do_req(1'b0, 2'b01, 1'b0, 32'h3FF, 32'h0, 2, got, gerr, expd);
    check("lh_wrap_rdata", got, 32'hFFFF8001);

    // Reserved size: no memory access, error response held for 3 cycles.
    mc0 = mem_cycles;
    do_req(1'b0, 2'b11, 1'b0, 32'h040, 32'h0, 3, got, gerr, expd);
    check("rsvd_err",    32'(gerr), 32'h1);
    check("rsvd_rdata",  got, 32'h0);
    check("rsvd_cycles", 32'(mem_cycles - mc0), 32'd0);

    // Reset during the third byte of a word store to 0x020.
    chk_en       = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h020;
    req_wdata    = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_b0_en",   32'(mem_en),   32'h1);
    check("abort_b0_addr", 32'(mem_addr), 32'h020);
    @(posedge clk); #1;
    check("abort_b1_addr", 32'(mem_addr), 32'h021);
    @(posedge clk); #1;
    check("abort_b2_en",   32'(mem_en),   32'h1);
    reset = 1'b1;
    #1;
    check("abort_en_drop",    32'(mem_en),     32'h0);
    check("abort_we_drop",    32'(mem_we),     32'h0);
    check("abort_req_ready",  32'(req_ready),  32'h1);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    ref_mem[10'h020] = 8'h0D;
    ref_mem[10'h021] = 8'hF0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_resp_valid", 32'(resp_valid), 32'h0);
      check("post_abort_req_ready",  32'(req_ready),  32'h1);
    end
    @(posedge clk); #1;
    check("abort_m020", 32'(mem[10'h020]), 32'h0D);
    check("abort_m021", 32'(mem[10'h021]), 32'hF0);
    check("abort_m022", 32'(mem[10'h022]), 32'(ref_mem[10'h022]));
    check("abort_m023", 32'(mem[10'h023]), 32'(ref_mem[10'h023]));
    chk_en = 1'b1;
    do_req(1'b0, 2'b00, 1'b0, 32'h020, 32'h0, 0, got, gerr, expd);
    check("post_abort_lw",     got, expd);
    check("post_abort_lw_low", 32'(got[15:0]), 32'hF00D);

    // Back-to-back word loads with resp_ready high at the response.
    c0 = cyc;
    do_req(1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 0, got, gerr, expd);
    check("b2b_first", got, 32'hDEADBEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h3FE, 32'h0, 0, got, gerr, expd);
    check("b2b_second", got, expd);
    check("b2b_total_cycles", 32'(cyc - c0), 32'd12);

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_req(1'($urandom), sz, 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), got, gerr, expd);
      check("rand_rdata", got, expd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    mism = 0;
    for (int i = 0; i < MSIZE; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image_mismatches", 32'(mism), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
